morse_sequencer: RTL and testbench

- Programmable Morse keyer/sequencer for the signal-lamp and buzzer datapath.
- Replaces a hard-wired 24-step blink table: a requester loads a symbol string and pulses start, then the block keys the lamp output and gates a square-wave tone.
- Time base is one Morse unit derived from the 50 MHz board clock; tone is a fixed-frequency square wave present only while keyed.
- Sits between user/control logic and the lamp (oKEY) and speaker (oSOUND) pins.

---
 rtl/morse_pkg.sv | 37 +++
 rtl/morse_tone_gen.sv | 27 ++
 rtl/morse_sequencer.sv | 148 ++++++++++++++
 tb/tb_morse_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared symbol codes, state encoding and unit-multiple durations for the Morse keyer.
package morse_pkg;

  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_LGAP = 2'b10;
  localparam logic [1:0] SYM_WGAP = 2'b11;

  localparam logic [2:0] DOT_UNITS   = 3'd1;
  localparam logic [2:0] DASH_UNITS  = 3'd3;
  localparam logic [2:0] SPACE_UNITS = 3'd1;
  localparam logic [2:0] LGAP_UNITS  = 3'd2;
  localparam logic [2:0] WGAP_UNITS  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_GAP,
    ST_DONE
  } state_t;

  function automatic logic [2:0] symUnits(input state_t st, input logic [1:0] sym);
    case (st)
      ST_MARK: return (sym == SYM_DASH) ? DASH_UNITS : DOT_UNITS;
      ST_GAP:  return (sym == SYM_WGAP) ? WGAP_UNITS : LGAP_UNITS;
      default: return SPACE_UNITS;
    endcase
  endfunction

  // Gap codes have the MSB set; everything else is a keyed mark.
  function automatic state_t symState(input logic [1:0] sym);
    if (sym[1]) return ST_GAP;
    return ST_MARK;
  endfunction

endpackage

// File: rtl/morse_tone_gen.sv
// Square-wave tone divider; held at phase zero whenever iCLR is asserted.
module morse_tone_gen #(
  parameter int TONE_HALF = 131072
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iCLR,
  output logic oTONE
);

  localparam int CNT_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  logic [CNT_W-1:0] toneCnt;

  always_ff @(posedge iCLK) begin
    if (iRST || iCLR) begin
      toneCnt <= '0;
      oTONE   <= 1'b0;
    end else if (toneCnt == CNT_W'(TONE_HALF - 1)) begin
      toneCnt <= '0;
      oTONE   <= ~oTONE;
    end else begin
      toneCnt <= toneCnt + 1'b1;
    end
  end

endmodule

// File: rtl/morse_sequencer.sv
// Programmable Morse keyer: plays a latched symbol string on the lamp key and gates a tone.
//   state    | meaning
//   ST_IDLE  | waiting for iSTART
//   ST_MARK  | key on for a dot or dash
//   ST_SPACE | one-unit key-off after a mark
//   ST_GAP   | letter/word gap, key off
//   ST_DONE  | end-of-pass cycle with oDONE, back to idle
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int UNIT_DIV  = 12500000,
  parameter int TONE_HALF = 131072,
  parameter int MAX_SYM   = 16,
  parameter int LEN_W     = 5
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iSTART,
  input  logic                 iABORT,
  input  logic                 iREPEAT,
  input  logic [LEN_W-1:0]     iMSG_LEN,
  input  logic [2*MAX_SYM-1:0] iSYMBOLS,
  output logic                 oKEY,
  output logic                 oSOUND,
  output logic                 oBUSY,
  output logic                 oDONE
);

  localparam int UCNT_W = (UNIT_DIV > 1) ? $clog2(UNIT_DIV) : 1;
  localparam int IDX_W  = (MAX_SYM > 1) ? $clog2(MAX_SYM) : 1;

  state_t               state, stateNext;
  logic [2*MAX_SYM-1:0] symReg;
  logic [LEN_W-1:0]     lenReg, lenClamp;
  logic                 repeatReg;
  logic [IDX_W-1:0]     idx, idxNext, idxInc;
  logic [UCNT_W-1:0]    unitCnt;
  logic [2:0]           unitNum;
  logic [1:0]           curSym, nextSym;
  logic                 unitDone, stateEnd, lastSym;
  logic                 enter, latch, keyNext, busyNext, doneNext;
  logic                 toneBit;

  assign lenClamp = (iMSG_LEN > LEN_W'(MAX_SYM)) ? LEN_W'(MAX_SYM) : iMSG_LEN;
  assign idxInc   = idx + 1'b1;
  assign curSym   = symReg[{idx, 1'b0} +: 2];
  assign nextSym  = symReg[{idxInc, 1'b0} +: 2];
  assign unitDone = (unitCnt == UCNT_W'(UNIT_DIV - 1));
  assign stateEnd = unitDone && (unitNum == symUnits(state, curSym) - 3'd1);
  assign lastSym  = (LEN_W'(idx) + LEN_W'(1)) >= lenReg;

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    enter     = 1'b0;
    latch     = 1'b0;
    doneNext  = 1'b0;
    if (iABORT) begin
      stateNext = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iSTART) begin
            latch   = 1'b1;
            enter   = 1'b1;
            idxNext = '0;
            if (lenClamp == '0) stateNext = ST_DONE;
            else                stateNext = symState(iSYMBOLS[1:0]);
          end
        end
        ST_MARK: begin
          if (stateEnd) begin
            enter     = 1'b1;
            stateNext = ST_SPACE;
          end
        end
        ST_SPACE, ST_GAP: begin
          if (stateEnd) begin
            enter = 1'b1;
            if (!lastSym) begin
              idxNext   = idxInc;
              stateNext = symState(nextSym);
            end else if (repeatReg) begin
              // Done pulse rides on the first cycle of the next pass so the loop has no dead cycle.
              idxNext   = '0;
              stateNext = symState(symReg[1:0]);
              doneNext  = 1'b1;
            end else begin
              stateNext = ST_DONE;
            end
          end
        end
        ST_DONE: stateNext = ST_IDLE;
        default: stateNext = ST_IDLE;
      endcase
    end
    keyNext  = (stateNext == ST_MARK);
    busyNext = (stateNext == ST_MARK) || (stateNext == ST_SPACE) || (stateNext == ST_GAP);
    if (stateNext == ST_DONE) doneNext = 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= ST_IDLE;
      idx       <= '0;
      symReg    <= '0;
      lenReg    <= '0;
      repeatReg <= 1'b0;
      unitCnt   <= '0;
      unitNum   <= '0;
      oKEY      <= 1'b0;
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
      oKEY  <= keyNext;
      oBUSY <= busyNext;
      oDONE <= doneNext;
      if (latch) begin
        symReg    <= iSYMBOLS;
        lenReg    <= lenClamp;
        repeatReg <= iREPEAT;
      end
      if (enter || stateNext == ST_IDLE || stateNext == ST_DONE) begin
        unitCnt <= '0;
        unitNum <= '0;
      end else if (unitDone) begin
        unitCnt <= '0;
        unitNum <= unitNum + 3'd1;
      end else begin
        unitCnt <= unitCnt + 1'b1;
      end
    end
  end

  // Tone only advances while the key stays on across the edge, so each mark starts at phase zero
  // and the tone bit is already zero whenever oKEY is low.
  morse_tone_gen #(.TONE_HALF(TONE_HALF)) uToneGen (
    .iCLK (iCLK),
    .iRST (iRST),
    .iCLR (~(keyNext & oKEY)),
    .oTONE(toneBit)
  );

  assign oSOUND = toneBit;

endmodule

// File: tb/tb_morse_sequencer.sv
// Randomized and directed bench for morse_sequencer against a per-cycle waveform model.
module tb_morse_sequencer;

  localparam int UNIT_DIV  = 4;
  localparam int TONE_HALF = 2;
  localparam int MAX_SYM   = 16;
  localparam int LEN_W     = 5;

  logic                 iCLK = 1'b0;
  logic                 iRST, iSTART, iABORT, iREPEAT;
  logic [LEN_W-1:0]     iMSG_LEN;
  logic [2*MAX_SYM-1:0] iSYMBOLS;
  logic                 oKEY, oSOUND, oBUSY, oDONE;
  logic [3:0]           obs;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] expQ[$];

  assign obs = {oKEY, oBUSY, oDONE, oSOUND};

  always #5 iCLK = ~iCLK;

  morse_sequencer #(
    .UNIT_DIV(UNIT_DIV), .TONE_HALF(TONE_HALF), .MAX_SYM(MAX_SYM), .LEN_W(LEN_W)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iABORT(iABORT), .iREPEAT(iREPEAT),
    .iMSG_LEN(iMSG_LEN), .iSYMBOLS(iSYMBOLS),
    .oKEY(oKEY), .oSOUND(oSOUND), .oBUSY(oBUSY), .oDONE(oDONE)
  );

  // Expected {key,busy,done,sound} for every cycle after the start edge, built from symbol durations.
  task automatic model_msg(input logic [31:0] syms, input int len, input bit rpt, input int passes);
    int l, code, onC, offC;
    bit pend;
    expQ.delete();
    l = (len > MAX_SYM) ? MAX_SYM : len;
    if (l == 0) begin
      expQ.push_back(4'b0010);
      return;
    end
    for (int p = 0; p < passes; p++) begin
      pend = (p > 0);
      for (int k = 0; k < l; k++) begin
        code = int'((syms >> (2 * k)) & 32'd3);
        case (code)
          0:       begin onC = UNIT_DIV;     offC = UNIT_DIV;     end
          1:       begin onC = 3 * UNIT_DIV; offC = UNIT_DIV;     end
          2:       begin onC = 0;            offC = 2 * UNIT_DIV; end
          default: begin onC = 0;            offC = 6 * UNIT_DIV; end
        endcase
        for (int c = 0; c < onC; c++) begin
          expQ.push_back({1'b1, 1'b1, pend, ((c / TONE_HALF) % 2) == 1});
          pend = 1'b0;
        end
        for (int c = 0; c < offC; c++) begin
          expQ.push_back({1'b0, 1'b1, pend, 1'b0});
          pend = 1'b0;
        end
      end
    end
    if (!rpt) expQ.push_back(4'b0010);
  endtask

  task automatic start_msg(input logic [31:0] syms, input int len, input bit rpt);
    @(negedge iCLK);
    iSYMBOLS = syms;
    iMSG_LEN = LEN_W'(len);
    iREPEAT  = rpt;
    iSTART   = 1'b1;
    @(negedge iCLK);
    iSTART   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge iCLK);
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_hold: got %b expected 0000", obs);
    end
    iRST = 1'b0;
    @(negedge iCLK);
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_release: got %b expected 0000", obs);
    end
  endtask

  task automatic test_sos();
    logic [31:0] syms;
    int codes[11];
    int expRuns[9];
    int runs[$];
    int busyCnt, keyCnt, doneCnt, run;
    codes   = '{0, 0, 0, 2, 1, 1, 1, 2, 0, 0, 0};
    expRuns = '{4, 4, 4, 12, 12, 12, 4, 4, 4};
    syms = '0;
    busyCnt = 0; keyCnt = 0; doneCnt = 0; run = 0;
    for (int k = 0; k < 11; k++) syms |= 32'(codes[k]) << (2 * k);
    model_msg(syms, 11, 1'b0, 1);
    start_msg(syms, 11, 1'b0);
    for (int i = 0; i < expQ.size(); i++) begin
      vectors++;
      if (obs !== expQ[i]) begin
        miscompares++;
        $display("FAIL sos cycle %0d: got %b expected %b", i, obs, expQ[i]);
      end
      busyCnt += int'(oBUSY);
      keyCnt  += int'(oKEY);
      doneCnt += int'(oDONE);
      if (oKEY) run++;
      else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
      @(negedge iCLK);
    end
    vectors++;
    if (busyCnt != 112) begin
      miscompares++;
      $display("FAIL sos_busy_len: got %0d expected 112", busyCnt);
    end
    vectors++;
    if (keyCnt != 60) begin
      miscompares++;
      $display("FAIL sos_key_total: got %0d expected 60", keyCnt);
    end
    vectors++;
    if (doneCnt != 1) begin
      miscompares++;
      $display("FAIL sos_done_count: got %0d expected 1", doneCnt);
    end
    vectors++;
    if (runs.size() != 9) begin
      miscompares++;
      $display("FAIL sos_run_count: got %0d expected 9", runs.size());
    end else begin
      for (int r = 0; r < 9; r++) begin
        vectors++;
        if (runs[r] != expRuns[r]) begin
          miscompares++;
          $display("FAIL sos_run%0d: got %0d expected %0d", r, runs[r], expRuns[r]);
        end
      end
    end
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL sos_idle_after: got %b expected 0000", obs);
    end
  endtask

  task automatic test_tone();
    int soundCnt;
    soundCnt = 0;
    model_msg(32'h0, 1, 1'b0, 1);
    start_msg(32'h0, 1, 1'b0);
    for (int i = 0; i < expQ.size(); i++) begin
      vectors++;
      if (obs !== expQ[i]) begin
        miscompares++;
        $display("FAIL tone cycle %0d: got %b expected %b", i, obs, expQ[i]);
      end
      soundCnt += int'(oSOUND);
      @(negedge iCLK);
    end
    vectors++;
    if (soundCnt != UNIT_DIV / 2) begin
      miscompares++;
      $display("FAIL tone_high_cycles: got %0d expected %0d", soundCnt, UNIT_DIV / 2);
    end
  endtask

  task automatic test_len0();
    start_msg($urandom(), 0, 1'b0);
    vectors++;
    if (obs !== 4'b0010) begin
      miscompares++;
      $display("FAIL len0_done: got %b expected 0010", obs);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLK);
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL len0_idle cycle %0d: got %b expected 0000", i, obs);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] syms;
    syms = 32'h1;  // dash, dot
    model_msg(syms, 2, 1'b0, 1);
    start_msg(syms, 2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (obs !== expQ[i]) begin
        miscompares++;
        $display("FAIL abort_pre cycle %0d: got %b expected %b", i, obs, expQ[i]);
      end
      if (i == 5) iABORT = 1'b1;
      @(negedge iCLK);
    end
    iABORT = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL abort_post cycle %0d: got %b expected 0000", i, obs);
      end
      @(negedge iCLK);
    end
    start_msg(syms, 2, 1'b0);
    for (int i = 0; i < expQ.size(); i++) begin
      vectors++;
      if (obs !== expQ[i]) begin
        miscompares++;
        $display("FAIL abort_replay cycle %0d: got %b expected %b", i, obs, expQ[i]);
      end
      @(negedge iCLK);
    end
  endtask

  task automatic test_start_abort_idle();
    @(negedge iCLK);
    iSYMBOLS = 32'h0;
    iMSG_LEN = 5'd3;
    iREPEAT  = 1'b0;
    iSTART   = 1'b1;
    iABORT   = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    iABORT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL start_abort_idle cycle %0d: got %b expected 0000", i, obs);
      end
      @(negedge iCLK);
    end
  endtask

  task automatic test_busy_start();
    logic [31:0] syms;
    syms = 32'h21;  // dash, dot, lgap, dot
    model_msg(syms, 4, 1'b0, 1);
    start_msg(syms, 4, 1'b0);
    for (int i = 0; i < expQ.size(); i++) begin
      vectors++;
      if (obs !== expQ[i]) begin
        miscompares++;
        $display("FAIL busy_start cycle %0d: got %b expected %b", i, obs, expQ[i]);
      end
      if (i == 10) begin
        iSTART   = 1'b1;
        iMSG_LEN = 5'd1;
        iSYMBOLS = $urandom();
        iREPEAT  = 1'b1;
      end else begin
        iSTART = 1'b0;
      end
      @(negedge iCLK);
    end
    iREPEAT = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] syms;
    int len;
    for (int m = 0; m < 6; m++) begin
      syms = $urandom();
      len  = (m == 0) ? 20 : int'($urandom_range(1, 20));
      model_msg(syms, len, 1'b0, 1);
      start_msg(syms, len, 1'b0);
      for (int i = 0; i < expQ.size(); i++) begin
        vectors++;
        if (obs !== expQ[i]) begin
          miscompares++;
          $display("FAIL rand msg %0d len %0d cycle %0d: got %b expected %b", m, len, i, obs, expQ[i]);
        end
        @(negedge iCLK);
      end
    end
  endtask

  task automatic test_repeat();
    int doneIdx[$];
    model_msg(32'hC, 2, 1'b1, 4);  // dot, word gap
    start_msg(32'hC, 2, 1'b1);
    for (int i = 0; i < 100; i++) begin
      vectors++;
      if (obs !== expQ[i]) begin
        miscompares++;
        $display("FAIL repeat cycle %0d: got %b expected %b", i, obs, expQ[i]);
      end
      if (oDONE) doneIdx.push_back(i);
      @(negedge iCLK);
    end
    vectors++;
    if (doneIdx.size() != 3) begin
      miscompares++;
      $display("FAIL repeat_done_count: got %0d expected 3", doneIdx.size());
    end else begin
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (doneIdx[d] != 32 * (d + 1)) begin
          miscompares++;
          $display("FAIL repeat_done_at%0d: got %0d expected %0d", d, doneIdx[d], 32 * (d + 1));
        end
      end
    end
    iRST = 1'b1;
    @(negedge iCLK);
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL repeat_reset: got %b expected 0000", obs);
    end
    iRST = 1'b0;
    iREPEAT = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge iCLK);
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL repeat_post_reset cycle %0d: got %b expected 0000", i, obs);
      end
    end
  endtask

  initial begin
    iRST     = 1'b1;
    iSTART   = 1'b0;
    iABORT   = 1'b0;
    iREPEAT  = 1'b0;
    iMSG_LEN = '0;
    iSYMBOLS = '0;
    test_reset();
    test_sos();
    test_tone();
    test_len0();
    test_abort();
    test_start_abort_idle();
    test_busy_start();
    test_random();
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
